// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage miniRV pipeline: tracks EX/MEM/WB
// destinations, raises IF/ID stall and flushes, registers EX operand-forward selects.
module pipe_hazard_ctrl #(
    parameter int RF_AW  = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             id_valid,
    input  logic [RF_AW-1:0] id_rs1,
    input  logic [RF_AW-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RF_AW-1:0] id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall_if,
    output logic             flush_if,
    output logic             flush_id,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [RF_AW+2:0] o_dbg_wb
);

    localparam logic [RF_AW-1:0] X0 = '0;

    logic             r_ex_valid, r_ex_we, r_ex_load;
    logic [RF_AW-1:0] r_ex_rd;
    logic             r_mem_valid, r_mem_we, r_mem_load;
    logic [RF_AW-1:0] r_mem_rd;
    logic             r_wb_valid, r_wb_we, r_wb_load;
    logic [RF_AW-1:0] r_wb_rd;
    logic [1:0]       r_fwd_a, r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_ex_wr, w_mem_wr;
    logic w_a_ex, w_b_ex, w_a_mem, w_b_mem;
    logic w_load_use, w_raw_any, w_hazard, w_ex_take;
    logic [1:0] w_fwd_a, w_fwd_b;

    // A stage can only be a producer if it holds a real writer to a non-x0 register.
    assign w_ex_wr  = r_ex_valid & r_ex_we & (r_ex_rd != X0);
    assign w_mem_wr = r_mem_valid & r_mem_we & (r_mem_rd != X0);

    assign w_a_ex  = w_ex_wr  & id_rs1_used & (r_ex_rd  == id_rs1);
    assign w_b_ex  = w_ex_wr  & id_rs2_used & (r_ex_rd  == id_rs2);
    assign w_a_mem = w_mem_wr & id_rs1_used & (r_mem_rd == id_rs1);
    assign w_b_mem = w_mem_wr & id_rs2_used & (r_mem_rd == id_rs2);

    assign w_load_use = id_valid & r_ex_load & (w_a_ex | w_b_ex);
    assign w_raw_any  = id_valid & (w_a_ex | w_b_ex | w_a_mem | w_b_mem);
    assign w_hazard   = FWD_EN ? w_load_use : w_raw_any;

    // Redirect wins over stall: the ID instruction is squashed, so holding it is pointless.
    assign stall_if  = ~cpu_rst & w_hazard & ~ex_redirect;
    assign flush_if  = ~cpu_rst & ex_redirect;
    assign flush_id  = stall_if | flush_if;
    assign w_ex_take = id_valid & ~stall_if & ~ex_redirect;

    // EX beats MEM because it holds the younger write to the same register.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (FWD_EN) begin
            if (w_a_ex && !r_ex_load) w_fwd_a = 2'b01;
            else if (w_a_mem)         w_fwd_a = 2'b10;
            if (w_b_ex && !r_ex_load) w_fwd_b = 2'b01;
            else if (w_b_mem)         w_fwd_b = 2'b10;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_ex_valid  <= 1'b0; r_ex_we  <= 1'b0; r_ex_load  <= 1'b0; r_ex_rd  <= '0;
            r_mem_valid <= 1'b0; r_mem_we <= 1'b0; r_mem_load <= 1'b0; r_mem_rd <= '0;
            r_wb_valid  <= 1'b0; r_wb_we  <= 1'b0; r_wb_load  <= 1'b0; r_wb_rd  <= '0;
            r_fwd_a     <= 2'b00;
            r_fwd_b     <= 2'b00;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wb_valid  <= r_mem_valid; r_wb_we  <= r_mem_we; r_wb_load  <= r_mem_load; r_wb_rd  <= r_mem_rd;
            r_mem_valid <= r_ex_valid;  r_mem_we <= r_ex_we;  r_mem_load <= r_ex_load;  r_mem_rd <= r_ex_rd;
            if (w_ex_take) begin
                r_ex_valid <= 1'b1;
                r_ex_we    <= id_rf_we;
                r_ex_load  <= id_is_load;
                r_ex_rd    <= id_rd;
                r_fwd_a    <= w_fwd_a;
                r_fwd_b    <= w_fwd_b;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_we    <= 1'b0;
                r_ex_load  <= 1'b0;
                r_ex_rd    <= '0;
                r_fwd_a    <= 2'b00;
                r_fwd_b    <= 2'b00;
            end
            if (stall_if && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_if && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign ex_fwd_a  = r_fwd_a;
    assign ex_fwd_b  = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    // WB needs no action with a write-first regfile; it is exposed for observation only.
    assign o_dbg_wb  = {r_wb_valid, r_wb_we, r_wb_load, r_wb_rd};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance (FWD_EN=1, CNT_W=16) and a
// stall-only instance (FWD_EN=0, CNT_W=2) share one ID stimulus stream.
module tb_pipe_hazard_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic        id_rf_we = 1'b0, id_is_load = 1'b0;
    logic        ex_redirect = 1'b0;

    logic        f_stall_if, f_flush_if, f_flush_id;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_stall_cnt, f_flush_cnt;
    logic [7:0]  f_dbg_wb;
    logic        n_stall_if, n_flush_if, n_flush_id;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [1:0]  n_stall_cnt, n_flush_cnt;
    logic [7:0]  n_dbg_wb;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl #(.RF_AW(5), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall_if(f_stall_if), .flush_if(f_flush_if), .flush_id(f_flush_id),
        .ex_fwd_a(f_fwd_a), .ex_fwd_b(f_fwd_b), .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt),
        .o_dbg_wb(f_dbg_wb)
    );

    pipe_hazard_ctrl #(.RF_AW(5), .FWD_EN(1'b0), .CNT_W(2)) dut_n (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall_if(n_stall_if), .flush_if(n_flush_if), .flush_id(n_flush_id),
        .ex_fwd_a(n_fwd_a), .ex_fwd_b(n_fwd_b), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt),
        .o_dbg_wb(n_dbg_wb)
    );

    // ---------------- driver tasks ----------------
    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_rf_we = we; id_is_load = ld;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1; ex_redirect = 1'b0; id_nop();
        next_cycle();
        next_cycle();
        cpu_rst = 1'b0;
    endtask

    // Present one instruction to the stall-only instance and hold it until accepted.
    task automatic issue_n(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, output int stalls);
        bit done;
        id_set(1'b1, rs1, rs2, u1, u2, rd, 1'b1, 1'b0);
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            sample();
            if (n_stall_if) stalls++;
            else done = 1'b1;
            next_cycle();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_timeout rd=%0d stalled=%0d required<8", rd, stalls);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cpu_rst = 1'b1; ex_redirect = 1'b1;
        id_set(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        sample();
        checks++; if (f_flush_if !== 1'b0) begin errors++; $display("FAIL rst_flush_if got=%b exp=0", f_flush_if); end
        checks++; if (f_flush_id !== 1'b0) begin errors++; $display("FAIL rst_flush_id got=%b exp=0", f_flush_id); end
        checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall_if got=%b exp=0", f_stall_if); end
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got=%b exp=0000", {f_fwd_a, f_fwd_b}); end
        checks++; if (f_stall_cnt !== 16'd0 || f_flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", f_stall_cnt, f_flush_cnt); end
        checks++; if (n_stall_cnt !== 2'd0 || n_flush_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt_n got=%0d/%0d exp=0/0", n_stall_cnt, n_flush_cnt); end
        ex_redirect = 1'b0;
        do_reset();
    endtask

    task automatic test_alu_forward();
        do_reset();
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
        sample();
        checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL alu_stall_a got=%b exp=0", f_stall_if); end
        next_cycle();
        id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub x6,x5,x1
        sample();
        checks++; if (f_stall_if !== 1'b0 || f_flush_id !== 1'b0) begin errors++; $display("FAIL alu_stall_b got=%b%b exp=00", f_stall_if, f_flush_id); end
        checks++; if (f_fwd_a !== 2'b00) begin errors++; $display("FAIL alu_fwd_prev got=%b exp=00", f_fwd_a); end
        next_cycle();
        id_nop();
        sample();
        checks++; if (f_fwd_a !== 2'b01) begin errors++; $display("FAIL alu_fwd_a got=%b exp=01", f_fwd_a); end
        checks++; if (f_fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_b got=%b exp=00", f_fwd_b); end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);  // lw x7,0(x1)
        sample();
        checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL lu_stall_lw got=%b exp=0", f_stall_if); end
        next_cycle();
        id_set(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // add x8,x7,x7
        sample();
        checks++; if (f_stall_if !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", f_stall_if); end
        checks++; if (f_flush_id !== 1'b1 || f_flush_if !== 1'b0) begin errors++; $display("FAIL lu_flush got=%b%b exp=10", f_flush_id, f_flush_if); end
        next_cycle();
        sample();
        checks++; if (f_stall_if !== 1'b0 || f_flush_id !== 1'b0) begin errors++; $display("FAIL lu_release got=%b%b exp=00", f_stall_if, f_flush_id); end
        checks++; if (f_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", f_stall_cnt); end
        checks++; if (f_fwd_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd got=%b exp=00", f_fwd_a); end
        next_cycle();
        id_nop();
        sample();
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b1010) begin errors++; $display("FAIL lu_fwd got=%b exp=1010", {f_fwd_a, f_fwd_b}); end
        next_cycle();
    endtask

    task automatic test_no_forward_stall();
        do_reset();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);  // addi x3,x1,imm
        sample();
        checks++; if (n_stall_if !== 1'b0) begin errors++; $display("FAIL nf_stall_addi got=%b exp=0", n_stall_if); end
        next_cycle();
        id_set(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // or x4,x3,x0
        sample();
        checks++; if (n_stall_if !== 1'b1) begin errors++; $display("FAIL nf_stall_c1 got=%b exp=1", n_stall_if); end
        checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL nf_fwd_inst_stall got=%b exp=0", f_stall_if); end
        next_cycle();
        sample();
        checks++; if (n_stall_if !== 1'b1) begin errors++; $display("FAIL nf_stall_c2 got=%b exp=1", n_stall_if); end
        checks++; if (n_fwd_a !== 2'b00) begin errors++; $display("FAIL nf_fwd_a_c2 got=%b exp=00", n_fwd_a); end
        next_cycle();
        sample();
        checks++; if (n_stall_if !== 1'b0) begin errors++; $display("FAIL nf_stall_c3 got=%b exp=0", n_stall_if); end
        checks++; if (n_stall_cnt !== 2'd2) begin errors++; $display("FAIL nf_stall_cnt got=%0d exp=2", n_stall_cnt); end
        next_cycle();
        id_nop();
        sample();
        checks++; if (n_fwd_a !== 2'b00 || n_fwd_b !== 2'b00) begin errors++; $display("FAIL nf_fwd got=%b%b exp=0000", n_fwd_a, n_fwd_b); end
        next_cycle();
    endtask

    task automatic test_redirect_priority();
        do_reset();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);  // lw x7
        next_cycle();
        id_set(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        sample();
        checks++; if (f_stall_if !== 1'b0) begin errors++; $display("FAIL rd_stall got=%b exp=0", f_stall_if); end
        checks++; if (f_flush_if !== 1'b1 || f_flush_id !== 1'b1) begin errors++; $display("FAIL rd_flush got=%b%b exp=11", f_flush_if, f_flush_id); end
        next_cycle();
        ex_redirect = 1'b0;
        id_nop();
        sample();
        checks++; if (f_flush_cnt !== 16'd1) begin errors++; $display("FAIL rd_flush_cnt got=%0d exp=1", f_flush_cnt); end
        checks++; if (f_stall_cnt !== 16'd0) begin errors++; $display("FAIL rd_stall_cnt got=%0d exp=0", f_stall_cnt); end
        checks++; if (f_flush_if !== 1'b0 || f_fwd_a !== 2'b00) begin errors++; $display("FAIL rd_after got=%b/%b exp=0/00", f_flush_if, f_fwd_a); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
        next_cycle();
        id_set(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);  // addi x5,x5,imm
        next_cycle();
        id_set(1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub x6,x5,x9
        sample();
        checks++; if (f_fwd_a !== 2'b01) begin errors++; $display("FAIL b2b_fwd_addi got=%b exp=01", f_fwd_a); end
        next_cycle();
        id_set(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); // add x10,x1,x5
        sample();
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0100) begin errors++; $display("FAIL b2b_ex_prio got=%b exp=0100", {f_fwd_a, f_fwd_b}); end
        next_cycle();
        id_nop();
        sample();
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0010) begin errors++; $display("FAIL b2b_mem_fwd got=%b exp=0010", {f_fwd_a, f_fwd_b}); end
        next_cycle();
    endtask

    task automatic test_x0_and_reset_mid_stall();
        do_reset();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw x0
        next_cycle();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // add x9,x0,x0
        sample();
        checks++; if (f_stall_if !== 1'b0 || n_stall_if !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b%b exp=00", f_stall_if, n_stall_if); end
        next_cycle();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);  // addi x0,x1,imm
        sample();
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_fwd_load got=%b exp=0000", {f_fwd_a, f_fwd_b}); end
        next_cycle();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        sample();
        checks++; if (f_stall_if !== 1'b0 || n_stall_if !== 1'b0) begin errors++; $display("FAIL x0_stall_alu got=%b%b exp=00", f_stall_if, n_stall_if); end
        next_cycle();
        id_nop();
        sample();
        checks++; if (f_fwd_a !== 2'b00) begin errors++; $display("FAIL x0_fwd_alu got=%b exp=00", f_fwd_a); end
        next_cycle();
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);  // lw x7
        next_cycle();
        id_set(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        sample();
        checks++; if (f_stall_if !== 1'b1) begin errors++; $display("FAIL mid_stall_pre got=%b exp=1", f_stall_if); end
        cpu_rst = 1'b1;
        #1;
        checks++; if (f_stall_if !== 1'b0 || f_flush_id !== 1'b0) begin errors++; $display("FAIL mid_stall_forced got=%b%b exp=00", f_stall_if, f_flush_id); end
        next_cycle();
        cpu_rst = 1'b0;
        sample();
        checks++; if ({f_stall_if, f_flush_if, f_flush_id} !== 3'b000) begin errors++; $display("FAIL mid_rst_comb got=%b exp=000", {f_stall_if, f_flush_if, f_flush_id}); end
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0000) begin errors++; $display("FAIL mid_rst_fwd got=%b exp=0000", {f_fwd_a, f_fwd_b}); end
        checks++; if (f_stall_cnt !== 16'd0 || f_flush_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", f_stall_cnt, f_flush_cnt); end
        next_cycle();
    endtask

    task automatic test_counter_saturation();
        int s;
        int total;
        do_reset();
        total = 0;
        issue_n(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, s);  total += s;   // addi x3
        issue_n(5'd3, 5'd0, 1'b1, 1'b1, 5'd4, s);  total += s;   // or x4,x3,x0: EX match
        checks++; if (s !== 2) begin errors++; $display("FAIL sat_ex_stalls got=%0d exp=2", s); end
        issue_n(5'd1, 5'd0, 1'b1, 1'b0, 5'd10, s); total += s;   // addi x10: independent
        issue_n(5'd4, 5'd1, 1'b1, 1'b1, 5'd11, s); total += s;   // add x11,x4,x1: MEM match
        checks++; if (s !== 1) begin errors++; $display("FAIL sat_mem_stalls got=%0d exp=1", s); end
        checks++; if (n_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt_mid got=%0d exp=3", n_stall_cnt); end
        issue_n(5'd11, 5'd0, 1'b1, 1'b1, 5'd12, s); total += s;  // sub x12,x11,x0
        id_nop();
        sample();
        checks++; if (total !== 5) begin errors++; $display("FAIL sat_total_stalls got=%0d exp=5", total); end
        checks++; if (n_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d exp=3", n_stall_cnt); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_no_forward_stall();
        test_redirect_priority();
        test_back_to_back();
        test_x0_and_reset_mid_stall();
        test_counter_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipelined successor of the single-cycle miniRV core in mySoC. The ID stage presents register usage and destination information for the instruction it holds. The block tracks destination info of the instructions in EX, MEM and WB. It generates IF/ID stall, IF/ID and ID/EX flush, and registered EX-stage operand-forward selects, and keeps saturating stall/flush performance counters.

Parameters:
RF_AW, 5, register-file address width; x0 is address 0.
FWD_EN, 1, 1 = resolve RAW hazards by forwarding (load-use stalls only); 0 = resolve every RAW hazard by stalling, and forward selects are held at 00.
CNT_W, 16, width of the performance counters.

Ports:
cpu_clk  in  1  core clock
cpu_rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  RF_AW  ID source register 1
id_rs2  in  RF_AW  ID source register 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  RF_AW  ID destination register
id_rf_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is a load
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
stall_if  out  1  hold PC and IF/ID register
flush_if  out  1  clear IF/ID to a bubble
flush_id  out  1  insert a bubble into ID/EX
ex_fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data, 11 never driven
ex_fwd_b  out  2  EX operand B source, same encoding as ex_fwd_a
stall_cnt  out  CNT_W  cycles in which stall_if was 1
flush_cnt  out  CNT_W  cycles in which ex_redirect was accepted

Behaviour:
- Stage trackers: EX, MEM and WB each hold {valid, rd, we, load}. Every cycle: WB<=MEM, MEM<=EX. EX<=ID info when id_valid & !stall_if & !ex_redirect; otherwise EX<=bubble (valid=0).
- A stage "matches" register r when: valid & we & rd!=0 & rd==r & the corresponding rsN_used=1.
- The register file is write-first, so WB-stage matches need no action.
- Load-use hazard (any FWD_EN): id_valid and either used source matches EX with EX.load=1.
- FWD_EN=0 hazard: id_valid and either used source matches EX or MEM, whether or not the instruction is a load.
- stall_if = hazard & !ex_redirect. flush_id = stall_if | ex_redirect. flush_if = ex_redirect.
- stall_if, flush_if and flush_id are combinational from the trackers and the id_* inputs. They are forced to 0 while cpu_rst=1.
- ex_redirect has priority over stall: PC takes the target, and both IF/ID and ID/EX are bubbled in the same cycle.
- Forward selects (FWD_EN=1) are computed in ID per source and registered into ex_fwd_a/ex_fwd_b with the EX tracker, so they have 1-cycle latency.
  - Source matches EX (non-load) -> 01.
  - Otherwise source matches MEM -> 10.
  - Otherwise -> 00.
  - EX has priority over MEM because it is the younger instruction.
  - A bubble entering EX loads 00. FWD_EN=0 always loads 00.
- Stall duration:
  - A load-use hazard stalls exactly 1 cycle; on the next cycle the load is in MEM and the select becomes 10.
  - With FWD_EN=0, an EX match stalls 2 cycles and a MEM match stalls 1 cycle.
- Counters: stall_cnt increments when stall_if=1. flush_cnt increments when ex_redirect=1. Both saturate at 2^CNT_W-1 and never wrap.
- Reset: all tracker valid=0, ex_fwd_a=ex_fwd_b=00, stall_cnt=flush_cnt=0, combinational outputs 0. Reset asserted mid-stall discards the stall; the first cycle after reset sees empty trackers.
- id_rd=0 never creates a hazard and never produces a forward.

Test Plan:
1. FWD_EN=1: "add x5" in ID at cycle n, then "sub x6,x5,x1" in ID at n+1 -> stall_if=0; at n+2 ex_fwd_a=01, ex_fwd_b=00.
2. FWD_EN=1: "lw x7" followed immediately by "add x8,x7,x7" -> stall_if=1 and flush_id=1 for exactly one cycle, stall_cnt=1; the next cycle has ex_fwd_a=ex_fwd_b=10.
3. FWD_EN=0: "addi x3" followed by "or x4,x3,x0" -> stall_if=1 for 2 consecutive cycles, stall_cnt=2, ex_fwd_a stays 00.
4. Load-use hazard and ex_redirect in the same cycle -> stall_if=0, flush_if=1, flush_id=1, flush_cnt=1, stall_cnt unchanged.
5. Writers to x0, plus an instruction reading x0 with rs1_used=1 -> no stall and ex_fwd_a=00. Pulse cpu_rst during a load-use stall -> all outputs 0 on the next cycle.
6. CNT_W=2: hold a FWD_EN=0 hazard chain for 5 stall cycles -> stall_cnt saturates at 3.
